// File: rtl/pwm_timer_channel.sv
// pwm_timer_channel: one PWM/timer channel (prescaler, period counter, shadowed compare, sticky IRQ); ports clk/rst_n, ctrl/period/divisor/dc regs, irq_clr in; o_pwm, o_irq, o_cnt out; o_pwm_n added when PWM_COMPL_OUT_EN is defined
module pwm_timer_channel #(
  parameter int CNT_W = 16
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst_n,
  input  logic [CNT_W-1:0] i_ctrl,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_divisor,
  input  logic [CNT_W-1:0] i_dc,
  input  logic             i_irq_clr,
  output logic             o_pwm,
  output logic             o_irq,
  output logic [CNT_W-1:0] o_cnt
`ifdef PWM_COMPL_OUT_EN
  ,
  output logic             o_pwm_n
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] div_cnt, period_sh, div_sh, dc_sh, div_max;
  logic en, mode, oneshot, irq_en, out_inv, tick, wrap, wrap_d, load, raw;
  assign en      = i_ctrl[0];
  assign mode    = i_ctrl[1];
  assign oneshot = i_ctrl[2];
  assign irq_en  = i_ctrl[3];
  assign out_inv = i_ctrl[4];
  assign div_max = (div_sh == '0) ? CNT_W'(1) : div_sh;
  assign tick    = (state_q == RUN) && (div_cnt == div_max - CNT_W'(1));
  assign wrap    = tick && en && (period_sh != '0) && (o_cnt == period_sh - CNT_W'(1));
  assign load    = ((state_q == IDLE) && en) || wrap;
  assign raw     = (state_q == IDLE) ? 1'b0
                 : mode ? wrap_d
                 : (state_q == RUN) && (period_sh != '0) && (o_cnt < dc_sh);
  always_comb begin
    state_d = state_q;
    if (!en)
      state_d = IDLE;
    else if (state_q == IDLE)
      state_d = RUN;
    else if ((state_q == RUN) && wrap && mode && oneshot)
      state_d = DONE;
  end
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n)
    if (!i_wb_rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      div_cnt   <= '0;
      o_cnt     <= '0;
      period_sh <= '0;
      div_sh    <= '0;
      dc_sh     <= '0;
      wrap_d    <= 1'b0;
      o_pwm     <= 1'b0;
      o_irq     <= 1'b0;
    end else begin
      wrap_d <= wrap;
      if (load) begin
        period_sh <= i_period;
        div_sh    <= i_divisor;
        dc_sh     <= i_dc;
      end
      if (((state_q == IDLE) && en) || ((state_q != IDLE) && !en)) begin
        div_cnt <= '0;
        o_cnt   <= '0;
      end else if (state_q == RUN) begin
        div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
        if (tick && (period_sh != '0))
          o_cnt <= wrap ? '0 : o_cnt + CNT_W'(1);
      end
      o_pwm <= raw ^ out_inv;
      o_irq <= (wrap && irq_en) || (o_irq && !i_irq_clr);
    end
  end
`ifdef PWM_COMPL_OUT_EN
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n)
    if (!i_wb_rst_n)
      o_pwm_n <= 1'b1;
    else
      o_pwm_n <= ~(raw ^ out_inv);
`endif
endmodule
